// File: rtl/multicycle_controller.sv
// multicycle_controller: RISC-V multicycle control FSM with ALU/immediate decode and a retired-instruction counter
module multicycle_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  State,
    output logic        Illegal,
    output logic [31:0] InstrCount
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    logic [3:0] state, state_next;
    logic [1:0] alu_op;
    logic [2:0] funct_ctl;
    logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, illegal;
    logic       is_lw, is_i, is_sw, is_r, is_beq, is_jal, supported, retire;

    assign is_lw     = op == 7'b0000011;
    assign is_i      = op == 7'b0010011;
    assign is_sw     = op == 7'b0100011;
    assign is_r      = op == 7'b0110011;
    assign is_beq    = op == 7'b1100011;
    assign is_jal    = op == 7'b1101111;
    assign supported = is_lw | is_i | is_sw | is_r | is_beq | is_jal;
    assign retire    = state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB || state == S_BEQ;

    // State register; reset forces FETCH immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_next;
    end

    // Retired-instruction counter, bumped on the edge leaving a final state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    InstrCount <= 32'd0;
        else if (retire) InstrCount <= InstrCount + 32'd1;
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = S_DECODE;
            S_DECODE:   state_next = (is_lw | is_sw) ? S_MEMADR :
                                     is_r   ? S_EXECUTER :
                                     is_i   ? S_EXECUTEI :
                                     is_beq ? S_BEQ :
                                     is_jal ? S_JAL : S_FETCH;
            S_MEMADR:   state_next = is_sw ? S_MEMWRITE : is_lw ? S_MEMREAD : S_FETCH;
            S_MEMREAD:  state_next = S_MEMWB;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    // Moore outputs per state; everything defaults to 0
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        adr_src   = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALU_ADD;
        case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = !supported;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALU_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU and immediate decode; write strobes are held low while reset is asserted
    always_comb begin
        funct_ctl  = funct3 == 3'b000 ? ({op[5], funct7b5} == 2'b11 ? 3'b001 : 3'b000) :
                     funct3 == 3'b010 ? 3'b101 :
                     funct3 == 3'b110 ? 3'b011 :
                     funct3 == 3'b111 ? 3'b010 : 3'b000;
        ALUControl = alu_op == ALU_SUB ? 3'b001 : alu_op == ALU_FUNCT ? funct_ctl : 3'b000;
        ImmSrc     = is_sw ? 2'b01 : is_beq ? 2'b10 : is_jal ? 2'b11 : 2'b00;
        PCWrite    = reset_n & (pc_update | (branch & Zero));
        AdrSrc     = adr_src;
        MemWrite   = reset_n & mem_write;
        IRWrite    = reset_n & ir_write;
        RegWrite   = reset_n & reg_write;
        Illegal    = reset_n & illegal;
        State      = state;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven per-cycle checks of the multicycle controller outputs
module tb_multicycle_controller;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [3:0]  st;
        logic [4:0]  str;
        logic [1:0]  rs;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  imm;
        logic [2:0]  alu;
        logic        ill;
        logic [31:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  op = OP_LW;
    logic [2:0]  funct3 = 3'b010;
    logic        funct7b5 = 1'b0;
    logic        Zero = 1'b0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;
    logic [31:0] InstrCount;
    logic [52:0] obs;
    int          passed = 0;
    int          total = 0;
    vec_t        vecs[$];

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .State(State), .Illegal(Illegal), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    assign obs = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, ALUControl, Illegal, InstrCount};

    function automatic void add(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                                input logic [3:0] st, input logic [4:0] str, input logic [1:0] rs,
                                input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
                                input logic [2:0] alu, input logic ill, input logic [31:0] cnt);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.st = st; v.str = str; v.rs = rs;
        v.sa = sa; v.sb = sb; v.imm = imm; v.alu = alu; v.ill = ill; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    function automatic logic [52:0] pack(input vec_t v);
        return {v.st, v.str, v.rs, v.sa, v.sb, v.imm, v.alu, v.ill, v.cnt};
    endfunction

    task automatic check(input string name, input logic [52:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, obs, exp);
    endtask

    initial begin
        // {State,PCW,AdrSrc,MemW,IRW,RegW,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Illegal,InstrCount}
        // lw
        add(OP_LW, 3'b010, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
        add(OP_LW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0);
        add(OP_LW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0);
        add(OP_LW, 3'b010, 0, 0, 4'd3, 5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        add(OP_LW, 3'b010, 0, 0, 4'd4, 5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        // sw
        add(OP_SW, 3'b010, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 1);
        add(OP_SW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0, 1);
        add(OP_SW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 1);
        add(OP_SW, 3'b010, 0, 0, 4'd5, 5'b01100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 1);
        // R sub
        add(OP_R, 3'b000, 1, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 2);
        add(OP_R, 3'b000, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 2);
        add(OP_R, 3'b000, 1, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0, 2);
        add(OP_R, 3'b000, 1, 0, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2);
        // R or
        add(OP_R, 3'b110, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 3);
        add(OP_R, 3'b110, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 3);
        add(OP_R, 3'b110, 0, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b011, 0, 3);
        add(OP_R, 3'b110, 0, 0, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3);
        // addi with bit30 set must stay add
        add(OP_I, 3'b000, 1, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 4);
        add(OP_I, 3'b000, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 4);
        add(OP_I, 3'b000, 1, 0, 4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 4);
        add(OP_I, 3'b000, 1, 0, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4);
        // beq taken
        add(OP_BEQ, 3'b000, 0, 1, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 5);
        add(OP_BEQ, 3'b000, 0, 1, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0, 5);
        add(OP_BEQ, 3'b000, 0, 1, 4'd9, 5'b10000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 5);
        // beq not taken
        add(OP_BEQ, 3'b000, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 6);
        add(OP_BEQ, 3'b000, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0, 6);
        add(OP_BEQ, 3'b000, 0, 0, 4'd9, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 6);
        // jal
        add(OP_JAL, 3'b000, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0, 7);
        add(OP_JAL, 3'b000, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 0, 7);
        add(OP_JAL, 3'b000, 0, 0, 4'd10, 5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 7);
        add(OP_JAL, 3'b000, 0, 0, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0, 7);
        // illegal opcode: not counted
        add(OP_BAD, 3'b000, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 8);
        add(OP_BAD, 3'b000, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1, 8);
        // lw to be aborted by reset in MEMREAD
        add(OP_LW, 3'b010, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 8);
        add(OP_LW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 8);
        add(OP_LW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 8);

        #3;
        check("reset_hold", {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 32'd0});
        @(posedge clk); #2;
        check("reset_edge", {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 32'd0});
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7; Zero = vecs[i].z;
            #1;
            check($sformatf("vec%0d", i), pack(vecs[i]));
            @(posedge clk); #1;
        end
        #1;
        check("memread", {4'd3, 5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 32'd8});
        #1;
        reset_n = 1'b0;
        #1;
        check("async_abort", {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 32'd0});
        @(posedge clk); #1;
        check("abort_hold", {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 32'd0});
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_reset_fetch", {4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 32'd0});
        @(posedge clk); #1;
        check("post_reset_decode", {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0, 32'd0});
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
